reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-read-port register file, successor to the single-write/two-read array used for the NPC integer registers. Adds configurable read-port count, byte-strobed writes, optional hardwired-zero entry 0, optional write-to-read bypass, and a sequential clear engine. The clear engine zeroes every entry after reset and holds `ready` low until it finishes. It sits between decode (read addresses) and writeback (write port) in the NPC core.

## Interface
- `ADDR_WIDTH`, default 5: entry address width; depth = 2**ADDR_WIDTH.
- `DATA_WIDTH`, default 32: entry width. Must be a multiple of 8.
- `NUM_READ`, default 2: number of asynchronous read ports, ≥1.
- `ZERO_REG`, default 1: 1 = entry 0 reads as 0 and ignores writes.
- `BYPASS`, default 1: 1 = a read of the address being written this cycle returns the post-write value.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ready` out 1: high once the clear sequence completes. Reset value 0.
- `wen` in 1: write enable. Ignored while `ready`=0.
- `waddr` in ADDR_WIDTH: write address.
- `wdata` in DATA_WIDTH: write data.
- `wstrb` in DATA_WIDTH/8: byte-lane write mask; bit i covers `wdata[8i+7:8i]`.
- `raddr` in NUM_READ*ADDR_WIDTH: packed read addresses; port p uses `[p*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rdata` out NUM_READ*DATA_WIDTH: packed read data with the same packing. Combinational; reads 0 while `ready`=0.

## Operation
- State machine has two states, CLEAR and RUN, plus a clear counter `clr_idx` (ADDR_WIDTH bits).
- `rst`=1 at an edge: state←CLEAR, `clr_idx`←0, `ready`←0. Array contents are not reset directly.
- In CLEAR, each cycle: `rf[clr_idx]`←0, then `clr_idx`←`clr_idx`+1.
- When `clr_idx`=2**ADDR_WIDTH−1 is written: state←RUN, `ready`←1. The counter wraps to 0 and is then unused.
- In RUN, on `wen`=1, write `rf[waddr]`, byte lane i taking `wdata` only where `wstrb[i]`=1. Other lanes keep their old value.
- A write with `wstrb`=0 is a no-op.
- With `ZERO_REG`=1: writes to address 0 are dropped, and any read of address 0 returns 0, including via the bypass path.
- Read port p returns the following, first match wins:
  - 0 if `ready`=0.
  - 0 if `ZERO_REG`=1 and the address is 0.
  - The bypass value if `BYPASS`=1, `wen`=1 and `raddr_p`=`waddr`. The bypass value is the stored word with strobed lanes replaced by `wdata`.
  - Otherwise `rf[raddr_p]`.
- With `BYPASS`=0, a same-cycle read returns the pre-write value.
- Read ports are independent. Any number of ports may read the same address in the same cycle.
- Reset asserted mid-CLEAR or mid-RUN restarts the clear from entry 0. Any write in the cycle where `rst`=1 is dropped.

## Timing
- Write latency: 1 edge. Read latency: 0 (combinational from `raddr`, the array and the bypass inputs).
- After `rst` falls at edge E0, the CLEAR phase lasts 2**ADDR_WIDTH cycles; `ready` rises after edge E0+2**ADDR_WIDTH. Default parameters: 32 cycles.
- The first accepted write is in the cycle where `ready`=1.
- No combinational path from `raddr` to `ready`.

## Structure
- Shared package `reg_file_pkg`:
  - state enum `rf_state_t` {CLEAR, RUN};
  - function `strb_merge(old, new, strb)` returning the byte-merged word, used by both the write path and the bypass path.
- One sub-module, `reg_file_rport`, instantiated NUM_READ times via generate. It applies the zero-register, not-ready and bypass masking to one port's raw array read.
- The array, FSM and clear counter stay in `reg_file_mp`.

## Test plan
- Reset then clear: hold `rst` 3 cycles, release.
  - `ready`=0 for exactly 32 cycles, then 1.
  - All 32 entries then read 0x00000000.
  - `wen`=1 during CLEAR leaves no trace.
- Byte strobe:
  - Write `rf[5]`=0xAABBCCDD with `wstrb`=0xF.
  - Then write 0x11223344 with `wstrb`=0x5.
  - Next cycle `rf[5]` reads 0xAA22CC44.
- Zero register and bypass:
  - Write address 0 with 0xFFFFFFFF: reads 0.
  - Same cycle, write 7←0x12345678 while port 1 reads 7: returns 0x12345678 with `BYPASS`=1, old value with `BYPASS`=0.
- Multi-port: with `NUM_READ`=3, write distinct values to 1, 2, 3, then read all ports at {3,1,3} → matching values on each port.
- Reset mid-operation:
  - Assert `rst` at CLEAR cycle 10: clear restarts at 0 and `ready` rises 32 cycles after release.
  - Assert `rst` in RUN after writes: all entries read 0 once `ready` returns.
  - Concurrent write during `rst` is discarded.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int unsigned MAX_DW = 512;
  localparam int unsigned MAX_SW = MAX_DW / 8;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_t;

  // Callers zero-extend narrower words and truncate the result back to their width.
  function automatic logic [MAX_DW-1:0] strb_merge(input logic [MAX_DW-1:0] old_word,
                                                   input logic [MAX_DW-1:0] new_word,
                                                   input logic [MAX_SW-1:0] strb);
    logic [MAX_DW-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < MAX_SW; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One read port: masks the raw array read for not-ready, entry 0 and write bypass.
module reg_file_rport
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                    ready,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic [DATA_WIDTH-1:0]   raw,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata_c
);

  // Zero-register masking takes priority over bypass so entry 0 never leaks wdata.
  always_comb begin
    rdata_c = raw;
    if (!ready) begin
      rdata_c = '0;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata_c = '0;
    end else if ((BYPASS != 0) && wen && (raddr == waddr)) begin
      rdata_c = DATA_WIDTH'(strb_merge(MAX_DW'(raw), MAX_DW'(wdata), MAX_SW'(wstrb)));
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with byte-strobed writes and a post-reset clear engine.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             ready,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf [DEPTH];

  rf_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_idx, clr_idx_nxt;
  logic                  ready_nxt;

  logic                  wr_en_c;
  logic [DATA_WIDTH-1:0] wr_word_c;

  // FSM and clear-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      ready   <= ready_nxt;
    end
  end

  // Walk every entry once, then hand over to normal operation.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ready_nxt   = ready;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_WIDTH'(1);
        if (clr_idx == '1) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN:     ready_nxt = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign wr_en_c   = ready && wen && !((ZERO_REG != 0) && (waddr == '0));
  assign wr_word_c = DATA_WIDTH'(strb_merge(MAX_DW'(rf[waddr]), MAX_DW'(wdata), MAX_SW'(wstrb)));

  // Array storage: cleared one entry per cycle in CLEAR, written from the write port in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        rf[clr_idx] <= '0;
      end else if (wr_en_c) begin
        rf[waddr] <= wr_word_c;
      end
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rport
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [DATA_WIDTH-1:0] port_raw;

    assign port_addr = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_raw  = rf[port_addr];

    reg_file_rport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rport (
      .ready   (ready),
      .raddr   (port_addr),
      .raw     (port_raw),
      .wen     (wen),
      .waddr   (waddr),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata_c (rdata[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
